pll_cen_gen: RTL and testbench

//  Parametrised clock-enable generator that follows the PLL wrapper. It derives NUM_CH

---
 rtl/pll_cen_gen.sv | 153 +++++++++++++++
 tb/tb_pll_cen_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pll_cen_gen.sv
// pll_cen_gen: generates per-channel clock enables after a PLL lock sequence.
// Divides one master clock into NUM_CH single-cycle enables and holds the core in reset until lock is stable.
//
// Ports:
//   clk        master clock
//   rst        asynchronous active-high reset
//   pll_locked PLL lock indication, asynchronous to clk
//   pause      level; freezes all channel counters while running
//   resync     pulse; realigns all channels to their initial phase
//   cen        per-channel one-cycle enable pulses
//   ready      high while running
//   rst_out    synchronous core reset, high unless running
module pll_cen_gen #(
    parameter int                          NUM_CH      = 4,
    parameter int                          CNT_WIDTH   = 8,
    parameter logic [NUM_CH*CNT_WIDTH-1:0] DIV         = {8'd16, 8'd16, 8'd8, 8'd8},
    parameter logic [NUM_CH*CNT_WIDTH-1:0] PHASE       = {8'd8, 8'd0, 8'd0, 8'd0},
    parameter int                          LOCK_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              pause,
    input  logic              resync,
    output logic [NUM_CH-1:0] cen,
    output logic              ready,
    output logic              rst_out
);

    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("pll_cen_gen: NUM_CH must be in 1..8");
    end

    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("pll_cen_gen: LOCK_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    state_t        state;
    logic [LW-1:0] lock_cnt;
    logic          lk_meta;
    logic          lk_s;
    logic          enter_run;
    logic          stay_run;

    // Two-flop synchroniser for the asynchronous lock input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
            ready    <= 1'b0;
            rst_out  <= 1'b1;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    lock_cnt <= '0;
                    if (lk_s) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!lk_s) begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state   <= RUN;
                        ready   <= 1'b1;
                        rst_out <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                        ready    <= 1'b0;
                        rst_out  <= 1'b1;
                    end
                end
                default: begin
                    state    <= WAIT_LOCK;
                    lock_cnt <= '0;
                    ready    <= 1'b0;
                    rst_out  <= 1'b1;
                end
            endcase
        end
    end

    // enter_run: the edge that moves SETTLE to RUN (channels load phase)
    // stay_run:  the edge keeps us in RUN (channels count)
    assign enter_run = (state == SETTLE) && lk_s && (lock_cnt == LOCK_LAST);
    assign stay_run  = (state == RUN) && lk_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CNT_WIDTH-1:0] D = DIV[i*CNT_WIDTH +: CNT_WIDTH];
        localparam logic [CNT_WIDTH-1:0] P = PHASE[i*CNT_WIDTH +: CNT_WIDTH];

        if (D == '0) begin : g_off
            assign cen[i] = 1'b0;
        end else begin : g_on
            localparam logic [CNT_WIDTH-1:0] LAST = D - 1'b1;

            if (P >= D) begin : g_bad_phase
                $error("pll_cen_gen: PHASE must be below DIV on every enabled channel");
            end

            logic [CNT_WIDTH-1:0] cnt;
            logic                 pulse;

            // resync outranks pause; both are ignored unless staying in RUN
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt   <= '0;
                    pulse <= 1'b0;
                end else if (enter_run || (stay_run && resync)) begin
                    cnt   <= P;
                    pulse <= 1'b0;
                end else if (stay_run && !pause) begin
                    pulse <= (cnt == LAST);
                    cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end else if (stay_run) begin
                    pulse <= 1'b0;
                end else begin
                    cnt   <= '0;
                    pulse <= 1'b0;
                end
            end

            assign cen[i] = pulse;
        end
    end

endmodule

// File: tb/tb_pll_cen_gen.sv
// tb_pll_cen_gen: directed table-driven bench for pll_cen_gen.
// Covers lock-up, default channel timing, lock glitch, lock loss, pause, resync and DIV=1/DIV=0 channels.
module tb_pll_cen_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pause;
    logic       resync;
    logic       pause2;
    logic       resync2;
    logic [3:0] cen;
    logic [3:0] cen2;
    logic       ready;
    logic       ready2;
    logic       rst_out;
    logic       rst_out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_cen_gen #(
        .NUM_CH     (4),
        .CNT_WIDTH  (8),
        .DIV        ({8'd16, 8'd16, 8'd8, 8'd8}),
        .PHASE      ({8'd8, 8'd0, 8'd0, 8'd0}),
        .LOCK_CYCLES(16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pause     (pause),
        .resync    (resync),
        .cen       (cen),
        .ready     (ready),
        .rst_out   (rst_out)
    );

    // ch0 DIV=1, ch1 disabled, ch2 DIV=3 phase 2, ch3 DIV=5 phase 0
    pll_cen_gen #(
        .NUM_CH     (4),
        .CNT_WIDTH  (8),
        .DIV        ({8'd5, 8'd3, 8'd0, 8'd1}),
        .PHASE      ({8'd0, 8'd2, 8'd0, 8'd0}),
        .LOCK_CYCLES(16)
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pause     (pause2),
        .resync    (resync2),
        .cen       (cen2),
        .ready     (ready2),
        .rst_out   (rst_out2)
    );

    typedef struct {
        logic       pause;
        logic       resync;
        logic [3:0] cen;
    } vec_t;

    vec_t tab_a[46];
    vec_t tab_b[81];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected enables of the second instance, k = cycles since RUN entry
    function automatic logic [3:0] exp2(input int k);
        logic [3:0] e;
        e    = 4'b0000;
        e[0] = (k >= 1);
        e[2] = (k >= 1) && ((k - 1) % 3 == 0);
        e[3] = (k >= 5) && (k % 5 == 0);
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        pause      = 1'b0;
        resync     = 1'b0;
        pause2     = 1'b0;
        resync2    = 1'b0;

        foreach (tab_a[k]) tab_a[k] = '{1'b0, 1'b0, 4'b0000};
        foreach (tab_b[k]) tab_b[k] = '{1'b0, 1'b0, 4'b0000};

        // Plain run: ch0/ch1 every 8, ch2 every 16, ch3 offset by 8
        tab_a[8].cen  = 4'b1011;
        tab_a[16].cen = 4'b0111;
        tab_a[24].cen = 4'b1011;
        tab_a[32].cen = 4'b0111;
        tab_a[40].cen = 4'b1011;

        // Pause over cycles 20..24, then resync+pause at the edge after 52
        tab_b[8].cen  = 4'b1011;
        tab_b[16].cen = 4'b0111;
        for (int k = 19; k <= 23; k++) tab_b[k].pause = 1'b1;
        tab_b[29].cen    = 4'b1011;
        tab_b[37].cen    = 4'b0111;
        tab_b[45].cen    = 4'b1011;
        tab_b[52].pause  = 1'b1;
        tab_b[52].resync = 1'b1;
        tab_b[61].cen    = 4'b1011;
        tab_b[69].cen    = 4'b0111;
        tab_b[77].cen    = 4'b1011;

        @(negedge clk);
        tick();
        tick();
        chk("reset_cen", 32'(cen), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_rst_out", 32'(rst_out), 32'd1);
        chk("reset_cen2", 32'(cen2), 32'd0);

        // Lock-up: RUN from the 19th edge after lock goes high
        rst        = 1'b0;
        pll_locked = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            chk($sformatf("lockup_ready_e%0d", e), 32'(ready), 32'(e >= 19));
            chk($sformatf("lockup_rst_out_e%0d", e), 32'(rst_out), 32'(e < 19));
            chk($sformatf("lockup_ready2_e%0d", e), 32'(ready2), 32'(e >= 19));
        end

        for (int k = 0; k <= 45; k++) begin
            chk($sformatf("runa_cen_c%0d", k), 32'(cen), 32'(tab_a[k].cen));
            chk($sformatf("runa_cen2_c%0d", k), 32'(cen2), 32'(exp2(k)));
            chk($sformatf("runa_ready_c%0d", k), 32'(ready), 32'd1);
            pause  = tab_a[k].pause;
            resync = tab_a[k].resync;
            if (k == 45) pll_locked = 1'b0;
            else tick();
        end

        // Lock loss timed so RUN would have pulsed at cycle 48
        tick();
        chk("loss_ready_c46", 32'(ready), 32'd1);
        chk("loss_cen2_c46", 32'(cen2), 32'(exp2(46)));
        tick();
        chk("loss_ready_c47", 32'(ready), 32'd1);
        chk("loss_cen2_c47", 32'(cen2), 32'(exp2(47)));
        tick();
        chk("loss_cen_c48", 32'(cen), 32'd0);
        chk("loss_ready_c48", 32'(ready), 32'd0);
        chk("loss_rst_out_c48", 32'(rst_out), 32'd1);
        chk("loss_cen2_c48", 32'(cen2), 32'd0);
        chk("loss_ready2_c48", 32'(ready2), 32'd0);

        // Relock with a one-cycle glitch while the settle count is 10
        pll_locked = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            tick();
            chk($sformatf("relock_ready_e%0d", e), 32'(ready), 32'(e >= 31));
            chk($sformatf("relock_rst_out_e%0d", e), 32'(rst_out), 32'(e < 31));
            if (e < 31) chk($sformatf("relock_cen_e%0d", e), 32'(cen), 32'd0);
            if (e == 11) pll_locked = 1'b0;
            if (e == 12) pll_locked = 1'b1;
        end

        for (int k = 0; k <= 80; k++) begin
            chk($sformatf("runb_cen_c%0d", k), 32'(cen), 32'(tab_b[k].cen));
            chk($sformatf("runb_cen2_c%0d", k), 32'(cen2), 32'(exp2(k)));
            chk($sformatf("runb_ready_c%0d", k), 32'(ready), 32'd1);
            pause  = tab_b[k].pause;
            resync = tab_b[k].resync;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
